cheat_loader: RTL and testbench
===============================

Name: cheat_loader

Overview:
- Sequences loading of cheat codes from the host download channel into the cheat-code match block.
- Assembles 16-byte code records, presents them on the 129-bit code bus, and generates the clock-bit strobe that commits each record.
- Issues the match block's clear pulse at the start of each download, counts committed codes, and flags overflow and partial records.
- Sits between the HPS/ioctl download path and the cheat match block, in the system clock domain.

Parameters:
- MAX_CODES, 32, capacity of the downstream match block; records beyond this count are discarded.
- CLR_CYCLES, 4, length in clk cycles of the clear pulse on codes_clr (≥1).
- STROBE_CYCLES, 2, clk cycles code[128] is held high, then held low, per record (≥1).
- DL_ADDR_W, 25, width of the download byte address.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dl_active  in  1  cheat download window; high while the host streams cheat data.
- dl_wr  in  1  byte write strobe, one cycle per byte.
- dl_addr  in  DL_ADDR_W  byte address within the download.
- dl_data  in  8  byte value.
- dl_wait  out  1  back-pressure to the host; the host must not write while this is high.
- code  out  129  {clock bit, flags[127:96], addr[95:64], compare[63:32], replace[31:0]} to the match block.
- codes_clr  out  1  reset for the match block's code table.
- code_count  out  $clog2(MAX_CODES+1)  number of records committed since the last clear.
- overflow  out  1  sticky: a complete record arrived while code_count == MAX_CODES.
- partial  out  1  sticky: the download ended with an incomplete record.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous):
  - All outputs 0, state IDLE, assembly buffer 0, lane mask 0.
  - Asserting reset mid-sequence aborts immediately, including mid-strobe. code[128] drops to 0 with no further strobe.
- Byte packing (big-endian within the record):
  - Lane k = dl_addr[3:0]; byte k is written to buffer bits [127-8k -: 8].
  - Each write sets lane_mask[k]. Writing the same lane again overwrites the byte.
  - code[127:0] always mirrors the buffer.
- IDLE:
  - A rising edge of dl_active (registered previous value) moves to CLEAR.
  - dl_wr is ignored while in IDLE.
- CLEAR:
  - codes_clr = 1 for exactly CLR_CYCLES cycles.
  - On entry: code_count, overflow, partial, buffer and lane_mask are cleared.
  - dl_wait = 1 throughout. Then go to COLLECT.
- COLLECT:
  - dl_wait = 0; each dl_wr packs its byte.
  - A write to lane 15 completes the record:
    - If code_count < MAX_CODES, go to STROBE_HI on the next cycle with dl_wait = 1 from that cycle.
    - Otherwise set overflow, clear the buffer and lane_mask, and stay in COLLECT.
  - Completion uses only the lane-15 write; lane_mask is not required to be full.
- STROBE_HI:
  - code[128] = 1 for STROBE_CYCLES cycles with the buffer stable.
  - code_count increments on the first cycle. Then go to STROBE_LO.
- STROBE_LO:
  - code[128] = 0 for STROBE_CYCLES cycles with the buffer stable.
  - Then clear the buffer and lane_mask and return to COLLECT.
  - This guarantees the match block sees exactly one rising edge per record.
- dl_wr while dl_wait = 1: the byte is dropped and nothing else is affected.
- dl_active falling:
  - In COLLECT: if lane_mask ≠ 0, set partial and discard the buffer. Go to IDLE.
  - In STROBE_HI/LO: finish the strobe sequence first, then go to IDLE.
  - In CLEAR: finish the clear, then go to IDLE.
- dl_active rising again while busy is ignored until IDLE is reached. Each new download always starts with a CLEAR.
- code_count saturates at MAX_CODES.
- Commit latency: lane-15 write on cycle T → code[128] high in cycles T+1 … T+STROBE_CYCLES; dl_wait is released at T+2·STROBE_CYCLES+1.

Test Plan:
- Single record: dl_active↑, wait for the clear, write bytes 0x00,0x00,0x00,0x01, 0x00,0x00,0x80,0x10, 0,0,0,0, 0,0,0,0xA5 → codes_clr high 4 cycles; code[127:0] = 0x00000001_00008010_00000000_000000A5; exactly one code[128] pulse of 2 cycles; code_count = 1.
- Overflow with MAX_CODES = 2: stream 3 full records → 2 strobes, code_count = 2, overflow = 1, no third rising edge on code[128].
- Partial record: 7 bytes then dl_active↓ → partial = 1, no strobe, state IDLE, code_count unchanged.
- Back-pressure violation: assert dl_wr with 0xFF on lane 0 during STROBE_HI → byte dropped; the next record's lane 0 holds the host's later value; the strobe completes normally.
- Re-download: after 3 committed codes, a new dl_active↑ → codes_clr pulse, code_count = 0, overflow = partial = 0.
- Async reset asserted in the 2nd STROBE_HI cycle → code = 0, busy = 0, dl_wait = 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/cheat_loader.sv
// Cheat-code loader: packs 16-byte download records onto the match block's
// 129-bit code bus, strobes each commit and tracks count, overflow and partials.
module cheat_loader #(
  parameter  int MAX_CODES     = 32,
  parameter  int CLR_CYCLES    = 4,
  parameter  int STROBE_CYCLES = 2,
  parameter  int DL_ADDR_W     = 25,
  localparam int CNT_W         = $clog2(MAX_CODES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dl_active,
  input  logic                 dl_wr,
  input  logic [DL_ADDR_W-1:0] dl_addr,
  input  logic [7:0]           dl_data,
  output logic                 dl_wait,
  output logic [128:0]         code,
  output logic                 codes_clr,
  output logic [CNT_W-1:0]     code_count,
  output logic                 overflow,
  output logic                 partial,
  output logic                 busy
);

  localparam int TMAX =
    (CLR_CYCLES > STROBE_CYCLES) ? CLR_CYCLES : STROBE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] CLR_LAST = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CODES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_STB_HI,
    S_STB_LO
  } state_t;

  state_t           r_state;
  logic             r_act_q;
  logic             r_end;
  logic [TW-1:0]    r_tmr;
  logic [127:0]     r_buf;
  logic [15:0]      r_mask;
  logic             r_stb;
  logic             r_clr;
  logic             r_wait;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_part;

  logic       w_rise;
  logic       w_fall;
  logic       w_end;
  logic [3:0] w_lane;
  logic [6:0] w_sh;
  logic       w_last;
  logic       w_unused;

  assign w_rise   = dl_active & ~r_act_q;
  assign w_fall   = ~dl_active & r_act_q;
  // An end-of-window seen mid-sequence is remembered until it can be honoured.
  assign w_end    = w_fall | r_end;
  assign w_lane   = dl_addr[3:0];
  assign w_sh     = {~w_lane, 3'b000};
  assign w_last   = (w_lane == 4'hF);
  assign w_unused = ^dl_addr[DL_ADDR_W-1:4];

  assign code       = {r_stb, r_buf};
  assign codes_clr  = r_clr;
  assign dl_wait    = r_wait;
  assign busy       = r_busy;
  assign code_count = r_count;
  assign overflow   = r_ovf;
  assign partial    = r_part;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_act_q <= 1'b0;
      r_end   <= 1'b0;
      r_tmr   <= '0;
      r_buf   <= '0;
      r_mask  <= '0;
      r_stb   <= 1'b0;
      r_clr   <= 1'b0;
      r_wait  <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_part  <= 1'b0;
    end else begin
      r_act_q <= dl_active;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_CLEAR;
            r_tmr   <= '0;
            r_clr   <= 1'b1;
            r_wait  <= 1'b1;
            r_busy  <= 1'b1;
            r_end   <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_part  <= 1'b0;
            r_buf   <= '0;
            r_mask  <= '0;
          end
        end
        S_CLEAR: begin
          if (w_fall) r_end <= 1'b1;
          if (r_tmr == CLR_LAST) begin
            r_tmr  <= '0;
            r_clr  <= 1'b0;
            r_wait <= 1'b0;
            if (w_end) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_end   <= 1'b0;
            end else begin
              r_state <= S_COLLECT;
            end
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_COLLECT: begin
          if (w_end) begin
            if (r_mask != '0) r_part <= 1'b1;
            r_buf   <= '0;
            r_mask  <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_end   <= 1'b0;
          end else if (dl_wr) begin
            r_buf[w_sh +: 8] <= dl_data;
            r_mask[w_lane]   <= 1'b1;
            if (w_last) begin
              if (r_count < CNT_MAX) begin
                r_state <= S_STB_HI;
                r_tmr   <= '0;
                r_stb   <= 1'b1;
                r_wait  <= 1'b1;
                r_count <= r_count + 1'b1;
              end else begin
                // Table full: drop the whole record, including this byte.
                r_ovf  <= 1'b1;
                r_buf  <= '0;
                r_mask <= '0;
              end
            end
          end
        end
        S_STB_HI: begin
          if (w_fall) r_end <= 1'b1;
          if (r_tmr == STB_LAST) begin
            r_tmr   <= '0;
            r_stb   <= 1'b0;
            r_state <= S_STB_LO;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_STB_LO: begin
          if (w_fall) r_end <= 1'b1;
          if (r_tmr == STB_LAST) begin
            r_tmr  <= '0;
            r_buf  <= '0;
            r_mask <= '0;
            r_wait <= 1'b0;
            if (w_end) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_end   <= 1'b0;
            end else begin
              r_state <= S_COLLECT;
            end
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_wait  <= 1'b0;
          r_clr   <= 1'b0;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cheat_loader.sv
// Bench for cheat_loader: default instance plus a MAX_CODES=2 instance,
// random records checked against a record-level model.
module tb_cheat_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        act  [2];
  logic        wr   [2];
  logic [24:0] addr [2];
  logic [7:0]  data [2];
  logic        wt   [2];
  logic [128:0] code [2];
  logic        clr  [2];
  logic        ovf  [2];
  logic        part [2];
  logic        busy [2];
  logic [5:0]  cnt_a;
  logic [1:0]  cnt_b;
  int          cnt  [2];

  int checks = 0;
  int failures = 0;
  bit tmo = 1'b0;

  int mx     [2] = '{32, 2};
  int m_cnt  [2] = '{0, 0};
  int m_ovf  [2] = '{0, 0};
  int m_part [2] = '{0, 0};

  int           rises    [2] = '{0, 0};
  int           hi_len   [2] = '{0, 0};
  int           last_w   [2] = '{0, 0};
  logic [127:0] last_cap [2];
  logic         prev_stb [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  cheat_loader u_dut (
    .clk(clk), .reset(reset),
    .dl_active(act[0]), .dl_wr(wr[0]),
    .dl_addr(addr[0]), .dl_data(data[0]),
    .dl_wait(wt[0]), .code(code[0]),
    .codes_clr(clr[0]), .code_count(cnt_a),
    .overflow(ovf[0]), .partial(part[0]),
    .busy(busy[0])
  );

  cheat_loader #(.MAX_CODES(2)) u_ovf (
    .clk(clk), .reset(reset),
    .dl_active(act[1]), .dl_wr(wr[1]),
    .dl_addr(addr[1]), .dl_data(data[1]),
    .dl_wait(wt[1]), .code(code[1]),
    .codes_clr(clr[1]), .code_count(cnt_b),
    .overflow(ovf[1]), .partial(part[1]),
    .busy(busy[1])
  );

  always_comb begin
    cnt[0] = int'(cnt_a);
    cnt[1] = int'(cnt_b);
  end

  // Strobe monitor: rising edges, value at the edge, high-pulse width.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (code[d][128] && !prev_stb[d]) begin
        rises[d]++;
        last_cap[d] = code[d][127:0];
        hi_len[d] = 1;
      end else if (code[d][128]) begin
        hi_len[d]++;
      end else if (prev_stb[d]) begin
        last_w[d] = hi_len[d];
      end
      prev_stb[d] = code[d][128];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (wt[d] && n < 50) begin
      tick();
      n++;
    end
    if (wt[d]) tmo = 1'b1;
  endtask

  task automatic write_byte(input int d, input int lane,
                            input logic [7:0] v);
    wait_ready(d);
    addr[d] = {21'($urandom), 4'(lane)};
    data[d] = v;
    wr[d] = 1'b1;
    tick();
    wr[d] = 1'b0;
  endtask

  task automatic write_record(input int d, input logic [127:0] rec,
                              input bit shuffle);
    int ord [15];
    int j;
    int t;
    for (int i = 0; i < 15; i++) ord[i] = i;
    if (shuffle) begin
      for (int i = 14; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = ord[i];
        ord[i] = ord[j];
        ord[j] = t;
      end
    end
    for (int i = 0; i < 15; i++)
      write_byte(d, ord[i], 8'(rec >> (8 * (15 - ord[i]))));
    write_byte(d, 15, rec[7:0]);
    if (m_cnt[d] < mx[d]) m_cnt[d]++;
    else m_ovf[d] = 1;
  endtask

  task automatic start_download(input int d, output int n, output bit ok);
    act[d] = 1'b0;
    tick();
    tick();
    act[d] = 1'b1;
    tick();
    n = 0;
    ok = 1'b1;
    while (clr[d] && n < 20) begin
      if (!wt[d] || !busy[d]) ok = 1'b0;
      n++;
      tick();
    end
    m_cnt[d] = 0;
    m_ovf[d] = 0;
    m_part[d] = 0;
  endtask

  task automatic end_download(input int d);
    int n = 0;
    act[d] = 1'b0;
    tick();
    while (busy[d] && n < 50) begin
      tick();
      n++;
    end
    if (busy[d]) tmo = 1'b1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (code[d] !== '0) begin
        failures++; $display("FAIL reset_code[%0d] got=%0h exp=0", d, code[d]);
      end
      checks++;
      if ({busy[d], wt[d], clr[d], ovf[d], part[d]} !== 5'b0) begin
        failures++;
        $display("FAIL reset_flags[%0d] got=%b exp=00000", d,
                 {busy[d], wt[d], clr[d], ovf[d], part[d]});
      end
      checks++;
      if (cnt[d] !== 0) begin
        failures++; $display("FAIL reset_count[%0d] got=%0d exp=0", d, cnt[d]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    bit ok;
    int r0;
    logic [127:0] exp_rec;
    logic [7:0] bytes [16] = '{8'h00, 8'h00, 8'h00, 8'h01,
                               8'h00, 8'h00, 8'h80, 8'h10,
                               8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'hA5};
    exp_rec = 128'h00000001_00008010_00000000_000000A5;
    tmo = 1'b0;
    r0 = rises[0];
    start_download(0, n, ok);
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL clr_len got=%0d exp=4", n);
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++; $display("FAIL clr_wait_busy got=%b exp=1", ok);
    end
    for (int i = 0; i < 15; i++) write_byte(0, i, bytes[i]);
    write_byte(0, 15, bytes[15]);
    m_cnt[0] = 1;
    checks++;
    if ({code[0][128], wt[0]} !== 2'b11) begin
      failures++; $display("FAIL lat_T1 got=%b exp=11", {code[0][128], wt[0]});
    end
    checks++;
    if (cnt[0] !== 1) begin
      failures++; $display("FAIL cnt_T1 got=%0d exp=1", cnt[0]);
    end
    tick();
    checks++;
    if ({code[0][128], wt[0]} !== 2'b11) begin
      failures++; $display("FAIL lat_T2 got=%b exp=11", {code[0][128], wt[0]});
    end
    tick();
    checks++;
    if ({code[0][128], wt[0]} !== 2'b01) begin
      failures++; $display("FAIL lat_T3 got=%b exp=01", {code[0][128], wt[0]});
    end
    tick();
    checks++;
    if ({code[0][128], wt[0], code[0][127:0] == exp_rec} !== 3'b011) begin
      failures++;
      $display("FAIL lat_T4 got=%b exp=011",
               {code[0][128], wt[0], code[0][127:0] == exp_rec});
    end
    tick();
    checks++;
    if (wt[0] !== 1'b0) begin
      failures++; $display("FAIL lat_T5 got=%b exp=0", wt[0]);
    end
    checks++;
    if (last_cap[0] !== exp_rec) begin
      failures++; $display("FAIL single_code got=%h exp=%h", last_cap[0], exp_rec);
    end
    checks++;
    if (rises[0] - r0 !== 1 || last_w[0] !== 2) begin
      failures++;
      $display("FAIL single_pulse got=%0d/%0d exp=1/2", rises[0] - r0, last_w[0]);
    end
    checks++;
    if (code[0][127:0] !== '0) begin
      failures++; $display("FAIL single_bufclr got=%h exp=0", code[0][127:0]);
    end
    checks++;
    if (tmo !== 1'b0) begin
      failures++; $display("FAIL single_timeout got=1 exp=0");
    end
  endtask

  task automatic test_random_records();
    logic [127:0] rec;
    int r0;
    tmo = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rec = rand128();
      r0 = rises[0];
      write_record(0, rec, 1'b1);
      wait_ready(0);
      checks++;
      if (rises[0] - r0 !== 1 || last_cap[0] !== rec || last_w[0] !== 2) begin
        failures++;
        $display("FAIL rand_rec%0d got=%h/%0d/%0d exp=%h/1/2", i,
                 last_cap[0], rises[0] - r0, last_w[0], rec);
      end
    end
    checks++;
    if (cnt[0] !== m_cnt[0]) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", cnt[0], m_cnt[0]);
    end
    checks++;
    if (tmo !== 1'b0) begin
      failures++; $display("FAIL rand_timeout got=1 exp=0");
    end
  endtask

  task automatic test_partial();
    int ord [15];
    int j;
    int t;
    int r0;
    tmo = 1'b0;
    r0 = rises[0];
    for (int i = 0; i < 15; i++) ord[i] = i;
    for (int i = 14; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = ord[i];
      ord[i] = ord[j];
      ord[j] = t;
    end
    for (int i = 0; i < 7; i++) write_byte(0, ord[i], 8'($urandom));
    end_download(0);
    m_part[0] = 1;
    checks++;
    if (part[0] !== 1'(m_part[0]) || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL partial_flag got=%b/%b exp=1/0", part[0], busy[0]);
    end
    checks++;
    if (cnt[0] !== m_cnt[0] || rises[0] !== r0) begin
      failures++;
      $display("FAIL partial_nocommit got=%0d/%0d exp=%0d/%0d",
               cnt[0], rises[0], m_cnt[0], r0);
    end
    checks++;
    if (code[0] !== '0) begin
      failures++; $display("FAIL partial_discard got=%h exp=0", code[0]);
    end
    checks++;
    if (tmo !== 1'b0) begin
      failures++; $display("FAIL partial_timeout got=1 exp=0");
    end
  endtask

  task automatic test_redownload();
    int n;
    bit ok;
    checks++;
    if (cnt[0] !== 3) begin
      failures++; $display("FAIL redl_before got=%0d exp=3", cnt[0]);
    end
    start_download(0, n, ok);
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL redl_clr got=%0d exp=4", n);
    end
    checks++;
    if (cnt[0] !== 0 || ovf[0] !== 1'b0 || part[0] !== 1'b0) begin
      failures++;
      $display("FAIL redl_clear got=%0d/%b/%b exp=0/0/0", cnt[0], ovf[0], part[0]);
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] rec1;
    logic [127:0] rec2;
    int r0;
    tmo = 1'b0;
    rec1 = rand128();
    rec2 = rand128();
    r0 = rises[0];
    write_record(0, rec1, 1'b0);
    addr[0] = 25'h0;
    data[0] = 8'hFF;
    wr[0] = 1'b1;
    tick();
    wr[0] = 1'b0;
    checks++;
    if (code[0] !== {1'b1, rec1}) begin
      failures++; $display("FAIL bp_stable got=%h exp=%h", code[0], {1'b1, rec1});
    end
    wait_ready(0);
    checks++;
    if (rises[0] - r0 !== 1 || last_w[0] !== 2 || code[0] !== '0) begin
      failures++;
      $display("FAIL bp_strobe got=%0d/%0d/%h exp=1/2/0",
               rises[0] - r0, last_w[0], code[0]);
    end
    write_record(0, rec2, 1'b1);
    wait_ready(0);
    checks++;
    if (last_cap[0] !== rec2) begin
      failures++; $display("FAIL bp_next got=%h exp=%h", last_cap[0], rec2);
    end
    checks++;
    if (cnt[0] !== m_cnt[0] || tmo !== 1'b0) begin
      failures++;
      $display("FAIL bp_count got=%0d/%b exp=%0d/0", cnt[0], tmo, m_cnt[0]);
    end
  endtask

  task automatic test_overflow();
    logic [127:0] recs [3];
    int n;
    bit ok;
    int r0;
    tmo = 1'b0;
    start_download(1, n, ok);
    r0 = rises[1];
    for (int i = 0; i < 3; i++) begin
      recs[i] = rand128();
      write_record(1, recs[i], 1'b1);
      wait_ready(1);
      tick();
      checks++;
      if (ovf[1] !== 1'(m_ovf[1]) || cnt[1] !== m_cnt[1]) begin
        failures++;
        $display("FAIL ovf_step%0d got=%b/%0d exp=%0d/%0d", i,
                 ovf[1], cnt[1], m_ovf[1], m_cnt[1]);
      end
    end
    checks++;
    if (rises[1] - r0 !== 2) begin
      failures++; $display("FAIL ovf_rises got=%0d exp=2", rises[1] - r0);
    end
    checks++;
    if (last_cap[1] !== recs[1] || code[1] !== '0) begin
      failures++;
      $display("FAIL ovf_last got=%h/%h exp=%h/0", last_cap[1], code[1], recs[1]);
    end
    checks++;
    if (tmo !== 1'b0) begin
      failures++; $display("FAIL ovf_timeout got=1 exp=0");
    end
  endtask

  task automatic test_end_during_strobe();
    logic [127:0] rec;
    int r0;
    int n = 0;
    bit clr_seen = 1'b0;
    tmo = 1'b0;
    rec = rand128();
    r0 = rises[0];
    write_record(0, rec, 1'b1);
    act[0] = 1'b0;
    tick();
    act[0] = 1'b1;
    while (busy[0] && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (busy[0] !== 1'b0 || wt[0] !== 1'b0) begin
      failures++; $display("FAIL eds_idle got=%b/%b exp=0/0", busy[0], wt[0]);
    end
    checks++;
    if (rises[0] - r0 !== 1 || last_w[0] !== 2 || last_cap[0] !== rec) begin
      failures++;
      $display("FAIL eds_strobe got=%0d/%0d/%h exp=1/2/%h",
               rises[0] - r0, last_w[0], last_cap[0], rec);
    end
    checks++;
    if (cnt[0] !== m_cnt[0]) begin
      failures++; $display("FAIL eds_count got=%0d exp=%0d", cnt[0], m_cnt[0]);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (clr[0] || busy[0]) clr_seen = 1'b1;
    end
    checks++;
    if (clr_seen !== 1'b0) begin
      failures++; $display("FAIL eds_rerise got=1 exp=0");
    end
    act[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstrobe();
    int n;
    bit ok;
    tmo = 1'b0;
    start_download(0, n, ok);
    write_record(0, rand128(), 1'b1);
    tick();
    checks++;
    if (code[0][128] !== 1'b1) begin
      failures++; $display("FAIL rst_pre got=%b exp=1", code[0][128]);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (code[0] !== '0) begin
      failures++; $display("FAIL rst_code got=%h exp=0", code[0]);
    end
    checks++;
    if ({busy[0], wt[0]} !== 2'b00 || cnt[0] !== 0) begin
      failures++;
      $display("FAIL rst_state got=%b/%b/%0d exp=0/0/0", busy[0], wt[0], cnt[0]);
    end
    act[0] = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0;
      wr[d] = 1'b0;
      addr[d] = '0;
      data[d] = '0;
    end
    #2;
    test_reset();
    test_single();
    test_random_records();
    test_partial();
    test_redownload();
    test_back_pressure();
    test_overflow();
    test_end_during_strobe();
    test_reset_midstrobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
